// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one handshaked memory port between instruction fetch and MEM-stage data.
// Define MEM_ARB_TIMEOUT_EN to abort busy states after TIMEOUT cycles and raise a sticky err.
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              dOwner_q, dOwner_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] iRdata_q, iRdata_d;
    logic [DATA_W-1:0] dRdata_q, dRdata_d;
    logic              dReq;
    logic              busy;
    logic              timeout;

    assign dReq = d_re | d_we;
    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;

    // An ack arriving on the expiry cycle takes priority over the abort.
    assign timeout = busy && !mem_ack && (tcnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        tcnt_d = tcnt_q;
        err_d  = err_q;
        if (!busy) begin
            tcnt_d = '0;
        end else if (!mem_ack) begin
            tcnt_d = tcnt_q + 1'b1;
        end
        if (timeout) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            err_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    localparam int unusedTimeout = TIMEOUT;

    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            dOwner_q <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            iRdata_q <= '0;
            dRdata_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            dOwner_q <= dOwner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            iRdata_q <= iRdata_d;
            dRdata_q <= dRdata_d;
        end
    end

    // Data wins unless a waiting fetch has already been passed over MAX_D_STREAK times.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dReq && (!i_req || (streak_q < SW'(MAX_D_STREAK)))) begin
                    state_d = BUSY_D;
                end else if (i_req) begin
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack || timeout) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        i_ready = 1'b0;
        d_ready = 1'b0;
        case (state_q)
            BUSY_I, BUSY_D: mem_req = 1'b1;
            DONE: begin
                i_ready = !dOwner_q;
                d_ready = dOwner_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        streak_d = streak_q;
        dOwner_d = dOwner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        iRdata_d = iRdata_q;
        dRdata_d = dRdata_q;
        if (state_q == IDLE && state_d == BUSY_D) begin
            dOwner_d = 1'b1;
            we_d     = d_we;
            addr_d   = d_addr;
            wdata_d  = d_wdata;
            if (!i_req) begin
                streak_d = '0;
            end else if (streak_q != SW'(MAX_D_STREAK)) begin
                streak_d = streak_q + 1'b1;
            end
        end else if (state_q == IDLE && state_d == BUSY_I) begin
            dOwner_d = 1'b0;
            we_d     = 1'b0;
            addr_d   = i_addr;
            streak_d = '0;
        end else if (busy && !we_q && (mem_ack || timeout)) begin
            // An aborted read returns zero rather than whatever is on the bus.
            if (dOwner_q) begin
                dRdata_d = mem_ack ? mem_rdata : '0;
            end else begin
                iRdata_d = mem_ack ? mem_rdata : '0;
            end
        end
    end

    assign mem_we    = we_q & mem_req;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = iRdata_q;
    assign d_rdata   = dRdata_q;
    assign stall     = (i_req & ~i_ready) | (dReq & ~d_ready);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model.
// Timeout scenarios run only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic [15:0] i_rdata;
    logic        i_ready;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall;
    logic        err;

    int          tests = 0;
    int          failures = 0;
    int          ackLat = 0;
    int          busyCnt = 0;
    logic [15:0] busMem [256];
    logic [15:0] modelMem [256];
    logic [15:0] expIr = '0;
    logic [15:0] expDr = '0;

    mem_arbiter #(
        .ADDR_W(16), .DATA_W(16), .MAX_D_STREAK(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and act as the memory: ack on the ackLat-th busy cycle (0 = never).
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_req) busyCnt++; else busyCnt = 0;
        if (mem_req && busyCnt == ackLat) begin
            mem_ack   = 1'b1;
            mem_rdata = busMem[mem_addr[7:0]];
            if (mem_we) busMem[mem_addr[7:0]] = mem_wdata;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
        end
    endtask

    task automatic waitDone(input string tag, input bit expData, input logic [15:0] expAddr,
                            input bit expWe, input logic [15:0] expWdata, input int expCycles);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 100) begin
            tick();
            n++;
            if (mem_req) begin
                chk({tag, "_addr"}, 32'(mem_addr), 32'(expAddr));
                chk({tag, "_we"}, 32'(mem_we), 32'(expWe));
                if (expWe) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(expWdata));
            end
            if (i_ready || d_ready) begin
                seen = 1'b1;
                chk({tag, "_owner"}, 32'(d_ready), 32'(expData));
                chk({tag, "_oneReady"}, 32'(i_ready & d_ready), 0);
                chk({tag, "_cycles"}, n, expCycles);
            end
        end
        chk({tag, "_readySeen"}, 32'(seen), 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        chk({tag, "_memReq"}, 32'(mem_req), 0);
        chk({tag, "_memWe"}, 32'(mem_we), 0);
        chk({tag, "_memAddr"}, 32'(mem_addr), 0);
        chk({tag, "_memWdata"}, 32'(mem_wdata), 0);
        chk({tag, "_iRdata"}, 32'(i_rdata), 0);
        chk({tag, "_dRdata"}, 32'(d_rdata), 0);
        chk({tag, "_readys"}, 32'({i_ready, d_ready}), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    initial begin
        logic [15:0] wd;
        logic [15:0] addr;
        int          kind;
        bit          seqD [6];
        seqD = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 256; i++) begin
            busMem[i]   = 16'(i * 257) ^ 16'h5A00;
            modelMem[i] = 16'(i * 257) ^ 16'h5A00;
        end
        busMem[8'h10]   = 16'hA5C3;
        modelMem[8'h10] = 16'hA5C3;

        // Reset state
        tick();
        tick();
        checkResetOutputs("reset");
        rst_n = 1'b1;
        tick();

        // Single fetch, ack after 3 busy cycles
        ackLat = 3;
        i_req  = 1'b1;
        i_addr = 16'h0010;
        #1;
        chk("fetch_stall_c0", 32'(stall), 1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("fetch_memReq", 32'(mem_req), 1);
            chk("fetch_stall", 32'(stall), 1);
            chk("fetch_noReady", 32'(i_ready), 0);
        end
        tick();
        chk("fetch_ready_c4", 32'(i_ready), 1);
        chk("fetch_rdata", 32'(i_rdata), 32'h0000A5C3);
        chk("fetch_memReqLow", 32'(mem_req), 0);
        chk("fetch_stallLow", 32'(stall), 0);
        expIr = 16'hA5C3;
        i_req = 1'b0;
        tick();
        chk("fetch_readyPulse", 32'(i_ready), 0);

        // Simultaneous fetch and data read: data first, fetch after
        ackLat = 2;
        i_req  = 1'b1;
        i_addr = 16'h0020;
        d_re   = 1'b1;
        d_addr = 16'h0040;
        waitDone("simul_d", 1'b1, 16'h0040, 1'b0, 16'h0, 3);
        expDr = modelMem[8'h40];
        chk("simul_dRdata", 32'(d_rdata), 32'(expDr));
        d_re = 1'b0;
        waitDone("simul_i", 1'b0, 16'h0020, 1'b0, 16'h0, 4);
        expIr = modelMem[8'h20];
        chk("simul_iRdata", 32'(i_rdata), 32'(expIr));
        i_req = 1'b0;
        tick();

        // Starvation guard: four data writes, one fetch, then data again
        ackLat  = 1;
        i_req   = 1'b1;
        i_addr  = 16'h0030;
        d_we    = 1'b1;
        d_addr  = 16'h0050;
        wd      = 16'($urandom);
        d_wdata = wd;
        for (int g = 0; g < 6; g++) begin
            waitDone($sformatf("streak_g%0d", g), seqD[g], seqD[g] ? 16'h0050 : 16'h0030,
                     seqD[g], wd, (g == 0) ? 2 : 3);
            if (d_ready) begin
                modelMem[8'h50] = wd;
                wd      = 16'($urandom);
                d_wdata = wd;
                if (g == 5) d_we = 1'b0;
            end
            if (i_ready) begin
                expIr = modelMem[8'h30];
                chk("streak_iRdata", 32'(i_rdata), 32'(expIr));
                i_req = 1'b0;
            end
        end
        tick();

        // Write with inputs changing mid-busy
        ackLat  = 2;
        d_we    = 1'b1;
        d_addr  = 16'h0100;
        d_wdata = 16'h1234;
        tick();
        chk("write_we", 32'(mem_we), 1);
        chk("write_addr", 32'(mem_addr), 32'h0100);
        chk("write_wdata", 32'(mem_wdata), 32'h1234);
        d_addr  = 16'h0ABC;
        d_wdata = 16'hFFFF;
        tick();
        chk("write_addrStable", 32'(mem_addr), 32'h0100);
        chk("write_wdataStable", 32'(mem_wdata), 32'h1234);
        tick();
        chk("write_ready", 32'(d_ready), 1);
        chk("write_dRdataKept", 32'(d_rdata), 32'(expDr));
        modelMem[8'h00] = 16'h1234;
        d_we = 1'b0;
        tick();

        // Reset mid BUSY_D, then a stray ack
        ackLat = 0;
        d_re   = 1'b1;
        d_addr = 16'h0077;
        tick();
        tick();
        chk("rstMid_busy", 32'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("rstMid");
        d_re = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 16'h5555;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rstMid_noReady", 32'({i_ready, d_ready}), 0);
            chk("rstMid_noReq", 32'(mem_req), 0);
        end
        expIr = '0;
        expDr = '0;

        // Randomized isolated transactions against the memory model
        for (int t = 0; t < 40; t++) begin
            kind   = int'($urandom_range(0, 3));
            addr   = 16'($urandom_range(0, 255));
            wd     = 16'($urandom);
            ackLat = int'($urandom_range(1, 5));
            if (kind == 0) begin
                i_req  = 1'b1;
                i_addr = addr;
            end else begin
                d_re    = (kind == 1) || (kind == 3);
                d_we    = (kind >= 2);
                d_addr  = addr;
                d_wdata = wd;
            end
            #1;
            chk("rand_stallReq", 32'(stall), 1);
            waitDone($sformatf("rand%0d_k%0d", t, kind), kind != 0, addr, kind >= 2, wd, ackLat + 1);
            if (kind == 0) begin
                expIr = modelMem[addr[7:0]];
            end else if (kind == 1) begin
                expDr = modelMem[addr[7:0]];
            end else begin
                modelMem[addr[7:0]] = wd;
            end
            chk("rand_iRdata", 32'(i_rdata), 32'(expIr));
            chk("rand_dRdata", 32'(d_rdata), 32'(expDr));
            chk("rand_stallDone", 32'(stall), 0);
            i_req = 1'b0;
            d_re  = 1'b0;
            d_we  = 1'b0;
            tick();
        end

`ifdef MEM_ARB_TIMEOUT_EN
        // No ack: abort after 8 busy cycles, zero data, sticky err
        ackLat = 0;
        d_re   = 1'b1;
        d_addr = 16'h0011;
        waitDone("tmo_noAck", 1'b1, 16'h0011, 1'b0, 16'h0, 9);
        chk("tmo_rdataZero", 32'(d_rdata), 0);
        chk("tmo_err", 32'(err), 1);
        d_re = 1'b0;
        tick();
        tick();
        chk("tmo_errSticky", 32'(err), 1);
        rst_n = 1'b0;
        tick();
        chk("tmo_errCleared", 32'(err), 0);
        rst_n = 1'b1;
        tick();
        // Ack on the 8th busy cycle wins over the timeout
        ackLat = 8;
        d_re   = 1'b1;
        waitDone("tmo_ack8", 1'b1, 16'h0011, 1'b0, 16'h0, 9);
        chk("tmo_ack8_rdata", 32'(d_rdata), 32'(modelMem[8'h11]));
        chk("tmo_ack8_err", 32'(err), 0);
        d_re = 1'b0;
        tick();
`else
        // Without the timeout a busy state waits indefinitely
        ackLat = 0;
        d_re   = 1'b1;
        d_addr = 16'h0011;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("noTmo_waiting", 32'({mem_req, d_ready}), 32'b10);
            chk("noTmo_err", 32'(err), 0);
        end
        d_re  = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
